// File: rtl/ov_capture_pkg.sv
// Shared types and constants for the OV7670 capture controller: FSM states, RGB565 field
// positions, luma weights and the decimation legality check.
package ov_capture_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StActive,
        StDone
    } state_e;

    localparam int unsigned RedMsb = 15;
    localparam int unsigned RedLsb = 11;
    localparam int unsigned GrnMsb = 10;
    localparam int unsigned GrnLsb = 5;
    localparam int unsigned BluMsb = 4;
    localparam int unsigned BluLsb = 0;

    localparam int unsigned LumaKr    = 2;
    localparam int unsigned LumaKg    = 5;
    localparam int unsigned LumaKb    = 1;
    localparam int unsigned LumaShift = 3;

    function automatic bit decim_ok(input int unsigned d);
        return (d == 1) || (d == 2) || (d == 4);
    endfunction

endpackage

// File: rtl/ov_rgb565_luma.sv
// Combinational RGB565 to 8-bit luma: Y = (2*R8 + 5*G8 + B8) >> 3 on an 11-bit sum.
module ov_rgb565_luma
    import ov_capture_pkg::*;
(
    input  logic [15:0] rgb,
    output logic [7:0]  y
);

    logic [10:0] r8, g8, b8, sum;

    always_comb begin
        // Channels widened to 8 bits by left shift, then zero-extended into the sum width.
        r8  = {3'b000, rgb[RedMsb:RedLsb], 3'b000};
        g8  = {3'b000, rgb[GrnMsb:GrnLsb], 2'b00};
        b8  = {3'b000, rgb[BluMsb:BluLsb], 3'b000};
        sum = 11'(LumaKr) * r8 + 11'(LumaKg) * g8 + 11'(LumaKb) * b8;
        y   = 8'(sum >> LumaShift);
    end

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame capture: RGB565 byte pairs to luma/binary frame-buffer writes with decimation.
// Define OV_CAPTURE_STATS_EN to add the LineCount and LastLinePix statistics outputs.
module ov7670_capture_ctrl
    import ov_capture_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DECIM    = 1,
    parameter int unsigned OUT_MODE = 1,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              PCLK,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        D,
    input  logic [7:0]        Threshold,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [7:0]        WrData,
    output logic              FrameStart,
    output logic              FrameDone,
    output logic              Busy,
    output logic              LineErr,
`ifdef OV_CAPTURE_STATS_EN
    output logic              FrameErr,
    output logic [10:0]       LineCount,
    output logic [11:0]       LastLinePix
`else
    output logic              FrameErr
`endif
);

    if (!decim_ok(DECIM)) begin : g_bad_decim
        $error("DECIM must be 1, 2 or 4");
    end

    localparam logic [11:0] HMax    = 12'(H_ACTIVE);
    localparam logic [10:0] VMax    = 11'(V_ACTIVE);
    localparam logic [11:0] ColMask = 12'(DECIM - 1);
    localparam logic [10:0] RowMask = 11'(DECIM - 1);

    state_e state_q, state_d;

    logic              vsync_q, href_q, phase_q;
    logic [7:0]        hi_q;
    logic [11:0]       col_q;
    logic [10:0]       row_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q, frame_start_q, frame_done_q, line_err_q, frame_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic vsync_fall, vsync_rise, href_fall;
    logic start_frame, end_frame, capture, line_end, write_ok;
    logic [7:0] luma, pix_data;

    assign vsync_fall = vsync_q & ~VSYNC;
    assign vsync_rise = ~vsync_q & VSYNC;
    assign href_fall  = href_q & ~HREF;

    always_ff @(posedge PCLK) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (VSYNC) state_d = StArm;
            StArm:    if (vsync_fall && Enable) state_d = StActive;
            StActive: if (vsync_rise) state_d = StDone;
            StDone:   state_d = StArm;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        Busy        = (state_q == StActive);
        start_frame = (state_q == StArm) && vsync_fall && Enable;
        end_frame   = (state_q == StActive) && vsync_rise;
        capture     = Busy && HREF;
        line_end    = Busy && href_fall;
    end

    ov_rgb565_luma u_luma (
        .rgb ({hi_q, D}),
        .y   (luma)
    );

    assign pix_data = (OUT_MODE == 1) ? {7'd0, luma >= Threshold} : luma;
    assign write_ok = (col_q < HMax) && (row_q < VMax) &&
                      ((col_q & ColMask) == 12'd0) && ((row_q & RowMask) == 11'd0);

    always_ff @(posedge PCLK) begin
        if (!Reset) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            phase_q       <= 1'b0;
            hi_q          <= 8'd0;
            col_q         <= 12'd0;
            row_q         <= 11'd0;
            addr_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 8'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            vsync_q       <= VSYNC;
            href_q        <= HREF;
            frame_start_q <= start_frame;
            frame_done_q  <= end_frame;
            wr_en_q       <= 1'b0;
            if (start_frame) begin
                addr_q      <= '0;
                wr_addr_q   <= '0;
                row_q       <= 11'd0;
                col_q       <= 12'd0;
                phase_q     <= 1'b0;
                line_err_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (end_frame && (row_q != VMax)) frame_err_q <= 1'b1;
            if (capture) begin
                if (!phase_q) begin
                    hi_q    <= D;
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    if (col_q != '1) col_q <= col_q + 12'd1;
                    if (col_q >= HMax) line_err_q <= 1'b1;
                    if (write_ok) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= pix_data;
                        // Saturate rather than wrap onto the start of the buffer.
                        if (addr_q != '1) addr_q <= addr_q + ADDR_W'(1);
                    end
                end
            end
            if (line_end) begin
                if (phase_q) line_err_q <= 1'b1;
                phase_q <= 1'b0;
                col_q   <= 12'd0;
                if (row_q != '1) row_q <= row_q + 11'd1;
            end
        end
    end

`ifdef OV_CAPTURE_STATS_EN
    always_ff @(posedge PCLK) begin
        if (!Reset) begin
            LineCount   <= 11'd0;
            LastLinePix <= 12'd0;
        end else begin
            if (end_frame) LineCount <= row_q;
            if (line_end) LastLinePix <= col_q;
        end
    end
`endif

    assign WrEn       = wr_en_q;
    assign WrAddr     = wr_addr_q;
    assign WrData     = wr_data_q;
    assign FrameStart = frame_start_q;
    assign FrameDone  = frame_done_q;
    assign LineErr    = line_err_q;
    assign FrameErr   = frame_err_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl: two instances (luma/DECIM=1 and binary/DECIM=2) on shared
// camera stimulus, compared against a per-pixel reference model of the write stream.
module tb_ov7670_capture_ctrl;

    localparam int H  = 12;
    localparam int V  = 6;
    localparam int AW = 10;

    logic          PCLK, Reset, Enable, VSYNC, HREF;
    logic [7:0]    D, Threshold;
    logic          we0, fs0, fd0, busy0, le0, fe0;
    logic          we1, fs1, fd1, busy1, le1, fe1;
    logic [AW-1:0] wa0, wa1;
    logic [7:0]    wd0, wd1;
`ifdef OV_CAPTURE_STATS_EN
    logic [10:0]   lc0, lc1;
    logic [11:0]   lp0, lp1;
`endif

    ov7670_capture_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .OUT_MODE(0), .ADDR_W(AW)
    ) u_dut0 (
        .PCLK(PCLK), .Reset(Reset), .Enable(Enable), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .Threshold(Threshold), .WrEn(we0), .WrAddr(wa0), .WrData(wd0), .FrameStart(fs0),
        .FrameDone(fd0), .Busy(busy0), .LineErr(le0), .FrameErr(fe0)
`ifdef OV_CAPTURE_STATS_EN
        , .LineCount(lc0), .LastLinePix(lp0)
`endif
    );

    ov7670_capture_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .OUT_MODE(1), .ADDR_W(AW)
    ) u_dut1 (
        .PCLK(PCLK), .Reset(Reset), .Enable(Enable), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .Threshold(Threshold), .WrEn(we1), .WrAddr(wa1), .WrData(wd1), .FrameStart(fs1),
        .FrameDone(fd1), .Busy(busy1), .LineErr(le1), .FrameErr(fe1)
`ifdef OV_CAPTURE_STATS_EN
        , .LineCount(lc1), .LastLinePix(lp1)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fs_cnt0 = 0, fs_cnt1 = 0, fd_cnt0 = 0, fd_cnt1 = 0;

    // Entry: [56] instance, [55:24] cycle, [23:16] data, [15:0] address.
    logic [63:0] act[$];
    logic [63:0] exp[$];
    logic [7:0]  pat[$];

    bit m_cap = 0;
    bit m_lerr = 0;
    int m_row = 0, m_addr0 = 0, m_addr1 = 0;

    initial begin
        PCLK = 0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (we0) act.push_back({7'd0, 1'b0, 32'(cyc), wd0, 6'd0, wa0});
        if (we1) act.push_back({7'd0, 1'b1, 32'(cyc), wd1, 6'd0, wa1});
        fs_cnt0 <= fs_cnt0 + int'(fs0);
        fs_cnt1 <= fs_cnt1 + int'(fs1);
        fd_cnt0 <= fd_cnt0 + int'(fd0);
        fd_cnt1 <= fd_cnt1 + int'(fd1);
    end

    task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge PCLK);
        #1;
        VSYNC = vs;
        HREF  = hr;
        D     = d;
    endtask

    task automatic model_pixel(input int r, input int c, input logic [15:0] px, input int ecyc);
        int y;
        y = (2 * (int'(px[15:11]) * 8) + 5 * (int'(px[10:5]) * 4) + int'(px[4:0]) * 8) / 8;
        if (m_cap && c < H && r < V) begin
            exp.push_back({7'd0, 1'b0, 32'(ecyc), 8'(y), 16'(m_addr0)});
            m_addr0++;
            if (c % 2 == 0 && r % 2 == 0) begin
                exp.push_back({7'd0, 1'b1, 32'(ecyc),
                               (y >= int'(Threshold)) ? 8'd1 : 8'd0, 16'(m_addr1)});
                m_addr1++;
            end
        end
    endtask

    task automatic drive_line(input int len);
        logic [7:0] b, hi;
        int r;
        r  = m_row;
        hi = 8'd0;
        if (m_cap && ((len % 2) != 0 || len / 2 > H)) m_lerr = 1;
        for (int i = 0; i < len; i++) begin
            if (pat.size() > 0) b = pat.pop_front();
            else b = 8'($urandom);
            tick(1'b0, 1'b1, b);
            if (i % 2 == 0) hi = b;
            else model_pixel(r, i / 2, {hi, b}, cyc + 1);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'($urandom));
        m_row++;
    endtask

    task automatic drive_vs_start();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'($urandom));
        tick(1'b0, 1'b0, 8'($urandom));
        m_cap = Enable;
        if (Enable) begin
            m_row = 0; m_addr0 = 0; m_addr1 = 0; m_lerr = 0;
        end
        tick(1'b0, 1'b0, 8'($urandom));
        tick(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic drive_vs_end();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'($urandom));
    endtask

    task automatic test_reset();
        Reset = 0; Enable = 1; VSYNC = 0; HREF = 0; D = 0; Threshold = 0;
        for (int i = 0; i < 3; i++) tick(1'($urandom), 1'($urandom), 8'($urandom));
        checks++;
        if ({we0, wa0, wd0, fs0, fd0, busy0, le0, fe0} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs0: got %b, expected all zero",
                     {we0, wa0, wd0, fs0, fd0, busy0, le0, fe0});
        end
        checks++;
        if ({we1, wa1, wd1, fs1, fd1, busy1, le1, fe1} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs1: got %b, expected all zero",
                     {we1, wa1, wd1, fs1, fd1, busy1, le1, fe1});
        end
        tick(1'b0, 1'b0, 8'd0);
        Reset = 1;
        act.delete();
        m_cap = 0;
        drive_line(2 * H);
        checks++;
        if (act.size() !== 0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_writes: got %0d writes busy=%b, expected 0 writes busy=0",
                     act.size(), busy0);
        end
    endtask

    task automatic test_frame();
        int fsb, fdb;
        for (int f = 0; f < 4; f++) begin
            act.delete(); exp.delete();
            Threshold = 8'($urandom);
            fsb = fs_cnt0 + fs_cnt1; fdb = fd_cnt0 + fd_cnt1;
            drive_vs_start();
            checks++;
            if ({busy0, busy1} !== 2'b11) begin
                failures++;
                $display("FAIL busy_active: got %b, expected 11", {busy0, busy1});
            end
            for (int r = 0; r < V; r++) begin
                drive_line(2 * H);
                if (f == 1 && r == 2) Enable = 0;
            end
            drive_vs_end();
            Enable = 1;
            checks++;
            if (act.size() !== exp.size()) begin
                failures++;
                $display("FAIL frame_writes: got %0d writes, expected %0d", act.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < act.size(); i++) begin
                checks++;
                if (act[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL write[%0d]: got %h, expected %h", i, act[i], exp[i]);
                end
            end
            checks++;
            if ((fs_cnt0 + fs_cnt1 - fsb) !== 2 || (fd_cnt0 + fd_cnt1 - fdb) !== 2) begin
                failures++;
                $display("FAIL frame_pulses: got start=%0d done=%0d, expected 2 and 2",
                         fs_cnt0 + fs_cnt1 - fsb, fd_cnt0 + fd_cnt1 - fdb);
            end
            checks++;
            if ({le0, fe0, le1, fe1, busy0, busy1} !== 6'd0) begin
                failures++;
                $display("FAIL frame_flags: got le/fe/busy %b, expected 000000",
                         {le0, fe0, le1, fe1, busy0, busy1});
            end
        end
    endtask

    task automatic test_threshold();
        act.delete(); exp.delete();
        Threshold = 8'h40;
        drive_vs_start();
        pat = '{8'hF8, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int r = 0; r < V; r++) drive_line(2 * H);
        drive_vs_end();
        checks++;
        if (act.size() < 5) begin
            failures++;
            $display("FAIL thr_count: got %0d writes, expected at least 5", act.size());
        end else begin
            if (act[0][23:16] !== 8'd62 || act[1][23:16] !== 8'h00 ||
                act[2][23:16] !== 8'd250 || act[4][23:16] !== 8'h01) begin
                failures++;
                $display("FAIL thr_values: got %h %h %h %h, expected 3e 00 fa 01",
                         act[0][23:16], act[1][23:16], act[2][23:16], act[4][23:16]);
            end
        end
        checks++;
        if (act.size() !== exp.size()) begin
            failures++;
            $display("FAIL thr_writes: got %0d writes, expected %0d", act.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < act.size(); i++) begin
            checks++;
            if (act[i] !== exp[i]) begin
                failures++;
                $display("FAIL thr_write[%0d]: got %h, expected %h", i, act[i], exp[i]);
            end
        end
    endtask

    task automatic test_long_line();
        for (int f = 0; f < 2; f++) begin
            act.delete(); exp.delete();
            Threshold = 8'($urandom);
            drive_vs_start();
            checks++;
            if ({le0, le1} !== 2'b00) begin
                failures++;
                $display("FAIL lerr_cleared: got %b, expected 00", {le0, le1});
            end
            for (int r = 0; r < V; r++) begin
                if (f == 0 && r == 1) drive_line(2 * H - 1);
                else if (f == 1 && r == 3) drive_line(2 * H + 6);
                else drive_line(2 * H);
            end
            drive_vs_end();
            checks++;
            if (act.size() !== exp.size()) begin
                failures++;
                $display("FAIL long_writes: got %0d writes, expected %0d", act.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < act.size(); i++) begin
                checks++;
                if (act[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL long_write[%0d]: got %h, expected %h", i, act[i], exp[i]);
                end
            end
            checks++;
            if ({le0, le1, fe0, fe1} !== {m_lerr, m_lerr, 2'b00}) begin
                failures++;
                $display("FAIL long_flags: got le/fe %b, expected %b",
                         {le0, le1, fe0, fe1}, {m_lerr, m_lerr, 2'b00});
            end
            for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'($urandom));
            checks++;
            if ({le0, le1} !== 2'b11) begin
                failures++;
                $display("FAIL lerr_sticky: got %b, expected 11", {le0, le1});
            end
        end
    endtask

    task automatic test_frame_err();
        int nl[3] = '{V - 1, V + 2, V};
        for (int f = 0; f < 3; f++) begin
            act.delete(); exp.delete();
            drive_vs_start();
            for (int r = 0; r < nl[f]; r++) drive_line(2 * H);
            drive_vs_end();
            checks++;
            if (act.size() !== exp.size()) begin
                failures++;
                $display("FAIL ferr_writes: got %0d writes, expected %0d", act.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < act.size(); i++) begin
                checks++;
                if (act[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL ferr_write[%0d]: got %h, expected %h", i, act[i], exp[i]);
                end
            end
            checks++;
            if ({fe0, fe1} !== {2{m_row != V}} || {le0, le1} !== 2'b00) begin
                failures++;
                $display("FAIL ferr_flags: got fe=%b le=%b, expected fe=%b le=00",
                         {fe0, fe1}, {le0, le1}, {2{m_row != V}});
            end
        end
    endtask

    task automatic test_midframe_reset();
        int fdb, fsb, pre;
        act.delete(); exp.delete();
        drive_vs_start();
        for (int r = 0; r < 3; r++) drive_line(2 * H);
        pre = exp.size();
        fdb = fd_cnt0 + fd_cnt1;
        @(posedge PCLK); #1; Reset = 0;
        @(posedge PCLK); #1;
        checks++;
        if ({we0, wa0, wd0, fs0, fd0, busy0, le0, fe0, we1, wa1, wd1, fs1, fd1, busy1, le1, fe1}
            !== 46'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got nonzero outputs (busy=%b%b addr=%0d/%0d)",
                     busy0, busy1, wa0, wa1);
        end
        Reset = 1;
        m_cap = 0;
        for (int r = 3; r < V; r++) drive_line(2 * H);
        drive_vs_end();
        checks++;
        if (act.size() !== pre || (fd_cnt0 + fd_cnt1 - fdb) !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: got %0d writes done=%0d, expected %0d writes done=0",
                     act.size(), fd_cnt0 + fd_cnt1 - fdb, pre);
        end
        act.delete(); exp.delete();
        fsb = fs_cnt0 + fs_cnt1;
        drive_vs_start();
        for (int r = 0; r < V; r++) drive_line(2 * H);
        drive_vs_end();
        checks++;
        if (act.size() !== exp.size() || (fs_cnt0 + fs_cnt1 - fsb) !== 2) begin
            failures++;
            $display("FAIL resume_frame: got %0d writes start=%0d, expected %0d writes start=2",
                     act.size(), fs_cnt0 + fs_cnt1 - fsb, exp.size());
        end
        checks++;
        if (act.size() == 0 || act[0][15:0] !== 16'd0) begin
            failures++;
            $display("FAIL resume_addr0: got %0d entries, first addr not 0", act.size());
        end
        for (int i = 0; i < exp.size() && i < act.size(); i++) begin
            checks++;
            if (act[i] !== exp[i]) begin
                failures++;
                $display("FAIL resume_write[%0d]: got %h, expected %h", i, act[i], exp[i]);
            end
        end
    endtask

    task automatic test_enable_low();
        int fsb, fdb;
        act.delete(); exp.delete();
        fsb = fs_cnt0 + fs_cnt1; fdb = fd_cnt0 + fd_cnt1;
        Enable = 0;
        drive_vs_start();
        checks++;
        if ({busy0, busy1} !== 2'b00) begin
            failures++;
            $display("FAIL disabled_busy: got %b, expected 00", {busy0, busy1});
        end
        for (int r = 0; r < V; r++) begin
            drive_line(2 * H);
            if (r == 1) Enable = 1;
        end
        checks++;
        if ({busy0, busy1} !== 2'b00) begin
            failures++;
            $display("FAIL late_enable_busy: got %b, expected 00", {busy0, busy1});
        end
        drive_vs_end();
        checks++;
        if (act.size() !== 0 || (fs_cnt0 + fs_cnt1 - fsb) !== 0 || (fd_cnt0 + fd_cnt1 - fdb) !== 0)
        begin
            failures++;
            $display("FAIL disabled_frame: got writes=%0d start=%0d done=%0d, expected 0 0 0",
                     act.size(), fs_cnt0 + fs_cnt1 - fsb, fd_cnt0 + fd_cnt1 - fdb);
        end
        fsb = fs_cnt0 + fs_cnt1;
        drive_vs_start();
        for (int r = 0; r < V; r++) drive_line(2 * H);
        drive_vs_end();
        checks++;
        if (act.size() !== exp.size() || (fs_cnt0 + fs_cnt1 - fsb) !== 2) begin
            failures++;
            $display("FAIL reenabled_frame: got %0d writes start=%0d, expected %0d start=2",
                     act.size(), fs_cnt0 + fs_cnt1 - fsb, exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_threshold();
        test_long_line();
        test_frame_err();
        test_midframe_reset();
        test_enable_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_ctrl.md
OV7670_CAPTURE_CTRL -- requirements
Module: ov7670_capture_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, 480, active lines per frame.
REQ-003 Parameter DECIM, 1, decimation factor in both axes; legal values 1, 2 and 4.
REQ-004 Parameter OUT_MODE, 1, output format: 0 = 8-bit luma, 1 = 1-bit binary.
REQ-005 Parameter ADDR_W, 19, write-address width.
REQ-006 PCLK  in  1  camera pixel clock; the only clock.
REQ-007 Reset  in  1  synchronous, active-low reset.
REQ-008 Enable  in  1  capture permit; sampled only at frame start.
REQ-009 VSYNC  in  1  frame sync; high = vertical blanking.
REQ-010 HREF  in  1  line valid; high = active bytes on D.
REQ-011 D  in  8  camera data bus, RGB565, high byte first.
REQ-012 Threshold  in  8  binarisation level; used only when OUT_MODE=1.
REQ-013 WrEn  out  1  frame-buffer write strobe.
REQ-014 WrAddr  out  ADDR_W  linear frame-buffer write address.
REQ-015 WrData  out  8  pixel data; when OUT_MODE=1, bit0 carries the pixel and bits7:1 are 0.
REQ-016 FrameStart, FrameDone  out  1 each  single-cycle pulses.
REQ-017 Busy, LineErr, FrameErr  out  1 each  status flags.

Function
REQ-018 The state machine SHALL have states IDLE, ARM, ACTIVE and DONE.
REQ-019 IDLE->ARM SHALL occur when VSYNC=1; ARM->ACTIVE SHALL occur on VSYNC 1->0 with Enable=1, pulsing FrameStart; otherwise the FSM SHALL stay in ARM.
REQ-020 ACTIVE->DONE SHALL occur on VSYNC 0->1, pulsing FrameDone; DONE->ARM SHALL occur on the next cycle.
REQ-021 In ACTIVE, bytes SHALL be captured only while HREF=1; byte 0 = {R[4:0],G[5:3]}, byte 1 = {G[2:0],B[4:0]}.
REQ-022 Luma SHALL be computed with R8=R<<3, G8=G<<2, B8=B<<3 and Y=(2*R8+5*G8+B8)>>3, using an 11-bit sum and an 8-bit result.
REQ-023 When OUT_MODE=1, the output pixel SHALL be (Y>=Threshold).
REQ-024 A pixel SHALL be written only if col%DECIM==0 and row%DECIM==0, with col<H_ACTIVE and row<V_ACTIVE.
REQ-025 WrEn SHALL assert exactly 1 cycle after the PCLK edge that samples byte 1 (latency 1).
REQ-026 WrAddr SHALL start at 0 at FrameStart and increment by 1 per write, never wrapping within a frame.
REQ-027 Column and byte-phase counters SHALL clear on each HREF 1->0; the row counter SHALL increment on each HREF 1->0.
REQ-028 If HREF falls on an odd byte, the partial pixel SHALL be discarded and LineErr set.
REQ-029 Pixels beyond H_ACTIVE SHALL not be written and SHALL set LineErr.
REQ-030 Lines beyond V_ACTIVE SHALL not be written.
REQ-031 FrameErr SHALL be set at FrameDone if the row count is not equal to V_ACTIVE.
REQ-032 LineErr and FrameErr SHALL be sticky, clearing only at FrameStart or on reset.
REQ-033 Busy SHALL equal 1 exactly in state ACTIVE.
REQ-034 A change of Enable while in ACTIVE SHALL have no effect on the current frame.

Reset
REQ-035 On Reset=0 at a PCLK edge, the FSM SHALL enter IDLE and all counters SHALL clear.
REQ-036 Reset values SHALL be WrEn=0, WrAddr=0, WrData=0, FrameStart=0, FrameDone=0, Busy=0, LineErr=0, FrameErr=0.
REQ-037 After a reset mid-frame, capture SHALL resume only after a full VSYNC high->low sequence.

Configuration
REQ-038 With macro OV_CAPTURE_STATS_EN defined, outputs LineCount[10:0] and LastLinePix[11:0] SHALL exist.
REQ-039 LineCount SHALL latch the row count at FrameDone; LastLinePix SHALL latch the completed pixel count at each HREF fall; both SHALL reset to 0.
REQ-040 Without OV_CAPTURE_STATS_EN, neither port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-041 Package ov_capture_pkg SHALL hold the state enum, RGB565 field positions, the luma coefficients 2/5/1 and shift 3, and the DECIM legality check.
REQ-042 Colour conversion SHALL be sub-module ov_rgb565_luma (combinational, RGB565 in -> 8-bit Y out).

Verification
REQ-043 Defaults, one 640x480 frame with 144-cycle line blanking -> 307200 writes, last WrAddr=307199, FrameDone once, LineErr=0, FrameErr=0.
REQ-044 DECIM=2, same frame -> 76800 writes, last WrAddr=76799.
REQ-045 OUT_MODE=1, Threshold=0x40: pixel bytes F8,00 -> Y=62 -> WrData=0x00; bytes FF,FF -> Y=250 -> WrData=0x01; each one cycle after byte 1.
REQ-046 One line with HREF high for 1279 cycles -> 639 writes on that line, LineErr=1 held until the next FrameStart.
REQ-047 Reset low for 1 cycle at row 100 -> all outputs 0, no writes until the next VSYNC fall, next frame starts at WrAddr=0.
REQ-048 Enable=0 at VSYNC fall -> no FrameStart, no writes, FSM stays in ARM, Busy=0.
